bup_3c120_fpga_sopc_button_pio: RTL and testbench

BUP_3C120_FPGA_SOPC_BUTTON_PIO -- requirements
Module: bup_3c120_fpga_sopc_button_pio

---
 rtl/bup_3c120_fpga_sopc_pio_pkg.sv | 29 ++
 rtl/bup_3c120_fpga_sopc_pio_debounce.sv | 33 +++
 rtl/bup_3c120_fpga_sopc_button_pio.sv | 97 +++++++++
 tb/tb_bup_3c120_fpga_sopc_button_pio.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bup_3c120_fpga_sopc_pio_pkg.sv
// Shared definitions for the button PIO: register word addresses and
// edge-detection mode encodings.
package bup_3c120_fpga_sopc_pio_pkg;

  typedef enum logic [1:0] {
    DATA      = 2'd0,
    DIRECTION = 2'd1,
    IRQ_MASK  = 2'd2,
    EDGE_CAP  = 2'd3
  } pio_reg_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Edge pulse vector for the selected mode; unknown modes behave as "any edge".
  function automatic logic [31:0] edge_detect(input int mode,
                                               input logic [31:0] cur,
                                               input logic [31:0] last);
    logic [31:0] res;
    case (mode)
      EDGE_RISING:  res = cur & ~last;
      EDGE_FALLING: res = ~cur & last;
      default:      res = cur ^ last;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bup_3c120_fpga_sopc_pio_debounce.sv
// Single-bit debouncer. The output follows the input only after the input
// has disagreed with it for CYCLES consecutive clocks; any agreement in
// between reloads the down-counter.
module bup_3c120_fpga_sopc_pio_debounce #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic data_out
);

  localparam int LOAD = (CYCLES > 1) ? CYCLES - 1 : 0;
  localparam int CW   = (LOAD > 0) ? $clog2(LOAD + 1) : 1;

  logic [CW-1:0] count;

  // Down-counter runs while input and output disagree; terminal count commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 1'b0;
      count    <= CW'(LOAD);
    end else if (sync_in == data_out) begin
      count <= CW'(LOAD);
    end else if (count == '0) begin
      data_out <= sync_in;
      count    <= CW'(LOAD);
    end else begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/bup_3c120_fpga_sopc_button_pio.sv
// Avalon-MM push-button / switch PIO: synchronised inputs, edge capture
// with write-1-to-clear, per-bit interrupt mask and a level irq.
// Optional per-bit debounce is built in when BUTTON_PIO_DEBOUNCE_EN is defined.
module bup_3c120_fpga_sopc_button_pio
  import bup_3c120_fpga_sopc_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_MODE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, data, prev;
  logic [WIDTH-1:0] edge_det, edge_cap, irq_mask;
  logic             wr_en;
  logic             wdata_unused;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_unused = ^writedata;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    bup_3c120_fpga_sopc_pio_debounce #(
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .sync_in  (sync2[i]),
      .data_out (data[i])
    );
  end
`else
  localparam int DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;
  assign data = sync2;
`endif

  // Previous-cycle data value for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= '0;
    else       prev <= data;
  end

  assign edge_det = WIDTH'(edge_detect(EDGE_MODE, 32'(data), 32'(prev)));

  // Sticky edge capture; a new edge wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
    end else if (wr_en && pio_reg_e'(address) == EDGE_CAP) begin
      edge_cap <= (edge_cap & ~writedata[WIDTH-1:0]) | edge_det;
    end else begin
      edge_cap <= edge_cap | edge_det;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        irq_mask <= '0;
    else if (wr_en && pio_reg_e'(address) == IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
  end

  // Zero-wait-state read mux, zero-extended to the bus width.
  always_comb begin
    readdata = '0;
    case (pio_reg_e'(address))
      DATA:     readdata[WIDTH-1:0] = data;
      DIRECTION:readdata            = '0;
      IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
      EDGE_CAP: readdata[WIDTH-1:0] = edge_cap;
      default:  readdata            = '0;
    endcase
  end

  // Level interrupt straight from the registers.
  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_bup_3c120_fpga_sopc_button_pio.sv
// Self-checking bench for the button PIO (WIDTH=4, falling-edge mode).
module tb_bup_3c120_fpga_sopc_button_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  in_val;
    logic        wr;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bup_3c120_fpga_sopc_button_pio #(
    .WIDTH           (4),
    .EDGE_MODE       (1),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  function automatic vec_t mk(input logic [3:0] in_val, input logic wr,
                              input logic [1:0] wa, input logic [31:0] wd,
                              input logic [1:0] ra, input logic [31:0] er,
                              input logic ei);
    vec_t v;
    v.in_val = in_val; v.wr = wr; v.wr_addr = wa; v.wr_data = wd;
    v.rd_addr = ra; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  // Queue the expectation, select the register, then compare once it settles.
  task automatic read_chk(input logic [1:0] a, input logic [31:0] er,
                          input logic ei, input string name);
    exp_t e;
    address = a;
    sb.push_back('{addr: a, rd: er, irq: ei});
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (readdata !== e.rd) begin
        errors++;
        $display("FAIL %s readdata[a%0d]: got 0x%08h expected 0x%08h", name, e.addr, readdata, e.rd);
      end
      checks++;
      if (irq !== e.irq) begin
        errors++;
        $display("FAIL %s irq: got %0b expected %0b", name, irq, e.irq);
      end
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    in_port = v.in_val;
    if (v.wr) begin
      chipselect = 1'b1; write_n = 1'b0; address = v.wr_addr; writedata = v.wr_data;
    end
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    read_chk(v.rd_addr, v.exp_rd, v.exp_irq, $sformatf("vec%0d", idx));
  endtask

  // Async reset must clear captures and mask with no clock edge.
  task automatic reset_no_clock_chk();
    #1 reset = 1'b1;
    read_chk(2'd3, 32'h0, 1'b0, "rst_async_ecap");
    read_chk(2'd2, 32'h0, 1'b0, "rst_async_mask");
  endtask

  vec_t vecs[32];

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;

    vecs[0]  = mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'h0, 0);
    vecs[1]  = mk(4'hF, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0);
    vecs[2]  = mk(4'hF, 1, 2'd2, 32'h1,        2'd3, 32'h0, 0);
    vecs[3]  = mk(4'hE, 0, 2'd0, 32'h0,        2'd2, 32'h1, 0);
    vecs[4]  = mk(4'hE, 0, 2'd0, 32'h0,        2'd0, 32'hE, 0);
    vecs[5]  = mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h1, 1);
    vecs[6]  = mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h0, 0);
    vecs[7]  = mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[8]  = mk(4'hA, 0, 2'd0, 32'h0,        2'd0, 32'hA, 0);
    vecs[9]  = mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h4, 0);
    vecs[10] = mk(4'hA, 1, 2'd2, 32'h4,        2'd3, 32'h4, 1);
    vecs[11] = mk(4'hA, 1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'h0, 1);
    vecs[12] = mk(4'hA, 1, 2'd0, 32'h5,        2'd0, 32'hA, 1);
    vecs[13] = mk(4'hA, 1, 2'd2, 32'h0,        2'd2, 32'h0, 0);
    vecs[14] = mk(4'hA, 0, 2'd0, 32'h0,        2'd3, 32'h4, 0);
    vecs[15] = mk(4'hF, 1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h0, 0);
    vecs[16] = mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[17] = mk(4'h0, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0);
    vecs[18] = mk(4'h0, 0, 2'd0, 32'h0,        2'd0, 32'h0, 0);
    vecs[19] = mk(4'h0, 0, 2'd0, 32'h0,        2'd3, 32'hF, 0);
    vecs[20] = mk(4'h0, 1, 2'd2, 32'hF,        2'd2, 32'hF, 1);
    vecs[21] = mk(4'hF, 1, 2'd3, 32'hF,        2'd3, 32'h0, 0);
    vecs[22] = mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[23] = mk(4'hE, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0);
    vecs[24] = mk(4'hE, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[25] = mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h1, 1);
    vecs[26] = mk(4'hE, 1, 2'd3, 32'h1,        2'd3, 32'h0, 0);
    vecs[27] = mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[28] = mk(4'hF, 0, 2'd0, 32'h0,        2'd3, 32'h0, 0);
    vecs[29] = mk(4'h0, 0, 2'd0, 32'h0,        2'd0, 32'hF, 0);
    vecs[30] = mk(4'h0, 0, 2'd0, 32'h0,        2'd0, 32'h0, 0);
    vecs[31] = mk(4'h0, 0, 2'd0, 32'h0,        2'd3, 32'hF, 1);

    // Held in reset with inputs high: nothing propagates.
    repeat (3) @(posedge clk);
    #1;
    read_chk(2'd0, 32'h0, 1'b0, "rst_data");
    read_chk(2'd3, 32'h0, 1'b0, "rst_ecap");
    read_chk(2'd2, 32'h0, 1'b0, "rst_mask");

    @(posedge clk); #1;
    reset = 1'b0;

`ifndef BUTTON_PIO_DEBOUNCE_EN
    for (int i = 0; i < 32; i++) run_vec(vecs[i], i);
    reset_no_clock_chk();
`else
    // Let the debouncer settle on the high inputs (falling mode: no capture).
    do_write(2'd2, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    read_chk(2'd0, 32'hF, 1'b0, "db_settle_data");
    read_chk(2'd3, 32'h0, 1'b0, "db_settle_ecap");

    @(negedge clk); in_port = 4'hD;
    repeat (5) @(posedge clk);
    @(negedge clk); in_port = 4'hF;
    repeat (20) @(posedge clk);
    #1;
    read_chk(2'd0, 32'hF, 1'b0, "db_glitch_data");
    read_chk(2'd3, 32'h0, 1'b0, "db_glitch_ecap");

    @(negedge clk); in_port = 4'hD;
    repeat (20) @(posedge clk);
    #1;
    read_chk(2'd0, 32'hD, 1'b1, "db_stable_data");
    read_chk(2'd3, 32'h2, 1'b1, "db_stable_ecap");
    reset_no_clock_chk();
`endif

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
